mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waiting for dm_ready (range 2..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port r  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ex_wb  input  2  writeback control from EX/MEM; [1]=RegWrite, [0]=MemtoReg.
REQ-005 SHALL have port mem_rd  input  1  instruction is a word load.
REQ-006 SHALL have port mem_wr  input  1  instruction is a word store.
REQ-007 SHALL have port alu_result  input  32  effective address or ALU result.
REQ-008 SHALL have port store_data  input  32  store write data.
REQ-009 SHALL have port ex_rd  input  5  destination register.
REQ-010 SHALL have port dm_req  output  1  data memory request, registered.
REQ-011 SHALL have port dm_we  output  1  write enable, registered.
REQ-012 SHALL have port dm_addr  output  32  word address, registered.
REQ-013 SHALL have port dm_wdata  output  32  write data, registered.
REQ-014 SHALL have port dm_ready  input  1  memory completion; load data valid on dm_rdata.
REQ-015 SHALL have port dm_rdata  input  32  load data.
REQ-016 SHALL have port wb_ctrl  output  2  control into MEM/WB register.
REQ-017 SHALL have port wb_data  output  32  data into MEM/WB register.
REQ-018 SHALL have port wb_rd  output  5  destination into MEM/WB register.
REQ-019 SHALL have port stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-020 SHALL have port exc  output  2  one-cycle pulse; [1]=bus timeout, [0]=misaligned.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, HOLD.
REQ-022 IDLE, no mem op (mem_rd=mem_wr=0): stall=0, wb_ctrl=ex_wb, wb_data=alu_result, wb_rd=ex_rd, zero added latency.
REQ-023 IDLE, mem op, alu_result[1:0]=00: stall=1 combinationally, wb_ctrl=00 (bubble); next edge: dm_req<=1, dm_we<=mem_wr, dm_addr<=alu_result, dm_wdata<=store_data, cycle counter<=0, state<=ACCESS.
REQ-024 IDLE, mem op, alu_result[1:0]!=00: no request; stall=1, wb_ctrl=00; next edge state<=HOLD with misalign flag set.
REQ-025 ACCESS: stall=1, wb_ctrl=00; dm_req, dm_we, dm_addr, dm_wdata held stable until dm_ready.
REQ-026 ACCESS, dm_ready=1: next edge dm_req<=0, ld_data<=dm_rdata (loads only), state<=HOLD.
REQ-027 ACCESS, dm_ready=0: counter increments; when counter=TIMEOUT-1, next edge dm_req<=0, timeout flag set, state<=HOLD.
REQ-028 dm_ready and timeout in same cycle: dm_ready SHALL win, no exception.
REQ-029 HOLD: stall=0, wb_rd=ex_rd; normal completion: wb_ctrl=ex_wb, wb_data=ld_data for load, alu_result for store.
REQ-030 HOLD with misalign/timeout flag: wb_ctrl=00, wb_data=0, exc bit asserted this cycle only; next edge flags cleared, state<=IDLE.
REQ-031 HOLD always returns to IDLE after exactly one cycle; back-to-back mem ops each re-enter ACCESS.
REQ-032 dm_ready outside ACCESS SHALL be ignored.
REQ-033 mem_rd and mem_wr both 1 SHALL be treated as a store.
REQ-034 Load latency with dm_ready on first ACCESS cycle: stall high 2 cycles, data at MEM/WB input in third cycle.

Reset
REQ-035 r=0 SHALL asynchronously force state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, ld_data=0, counter=0, flags=0.
REQ-036 Reset mid-ACCESS SHALL abort the request immediately; no exc pulse; after release stall follows REQ-022/023 from current inputs.

Verification
REQ-037 ALU op ex_wb=10, alu_result=0x5, ex_rd=3 -> same cycle wb_ctrl=10, wb_data=0x5, wb_rd=3, stall=0.
REQ-038 Load addr 0x100, dm_ready after 3 ACCESS cycles, rdata 0xDEADBEEF -> stall 4 cycles, then HOLD wb_ctrl=11, wb_data=0xDEADBEEF.
REQ-039 Store addr 0x200 data 0x1234 -> dm_we=1, dm_addr=0x200, dm_wdata=0x1234 stable until dm_ready; wb_ctrl=00 in HOLD.
REQ-040 Load addr 0x102 -> dm_req never asserts, exc=01 for one cycle, wb_ctrl=00.
REQ-041 Load, dm_ready never, TIMEOUT=16 -> dm_req drops after 16 cycles, exc=10 one cycle, stall released.
REQ-042 r low during ACCESS -> dm_req=0 without clock edge, state IDLE, exc=00.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data memory handshake, stall, misalign/timeout exceptions
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        r,
   input  logic [1:0]  ex_wb,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  ex_rd,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic [31:0] dm_rdata,
   output logic [1:0]  wb_ctrl,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        stall,
   output logic [1:0]  exc
);

   typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

   // Last wait cycle before the request is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mis_q, mis_d;
   logic        tmo_q, tmo_d;

   logic mem_op;
   logic misaligned;

   // A simultaneous read and write decodes as a store via dm_we <= mem_wr.
   assign mem_op     = mem_rd | mem_wr;
   assign misaligned = |alu_result[1:0];

   // Next-state logic: launch, wait for completion or timeout, then one HOLD cycle.
   always_comb begin
      state_d    = state_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      ld_data_d  = ld_data_q;
      cnt_d      = cnt_q;
      mis_d      = mis_q;
      tmo_d      = tmo_q;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  mis_d   = 1'b1;
                  state_d = HOLD;
               end else begin
                  dm_req_d   = 1'b1;
                  dm_we_d    = mem_wr;
                  dm_addr_d  = alu_result;
                  dm_wdata_d = store_data;
                  cnt_d      = 8'd0;
                  state_d    = ACCESS;
               end
            end
         end
         ACCESS: begin
            // Completion takes priority over a timeout landing on the same cycle.
            if (dm_ready) begin
               dm_req_d = 1'b0;
               if (!dm_we_q) begin
                  ld_data_d = dm_rdata;
               end
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == CNT_LAST) begin
                  dm_req_d = 1'b0;
                  tmo_d    = 1'b1;
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            mis_d   = 1'b0;
            tmo_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stage outputs toward MEM/WB and the pipeline freeze.
   always_comb begin
      stall   = 1'b0;
      wb_ctrl = ex_wb;
      wb_data = alu_result;
      wb_rd   = ex_rd;
      exc     = 2'b00;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               stall   = 1'b1;
               wb_ctrl = 2'b00;
            end
         end
         ACCESS: begin
            stall   = 1'b1;
            wb_ctrl = 2'b00;
         end
         HOLD: begin
            if (mis_q || tmo_q) begin
               wb_ctrl = 2'b00;
               wb_data = 32'd0;
               exc     = {tmo_q, mis_q};
            end else if (!dm_we_q) begin
               wb_data = ld_data_q;
            end
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // State and request registers; reset drops any outstanding request at once.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q    <= IDLE;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= 32'd0;
         dm_wdata_q <= 32'd0;
         ld_data_q  <= 32'd0;
         cnt_q      <= 8'd0;
         mis_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         ld_data_q  <= ld_data_d;
         cnt_q      <= cnt_d;
         mis_q      <= mis_d;
         tmo_q      <= tmo_d;
      end
   end

   assign dm_req   = dm_req_q;
   assign dm_we    = dm_we_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        r;
   logic [1:0]  ex_wb;
   logic        mem_rd, mem_wr;
   logic [31:0] alu_result, store_data;
   logic [4:0]  ex_rd;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ready;
   logic [31:0] dm_rdata;
   logic [1:0]  wb_ctrl;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        stall;
   logic [1:0]  exc;

   int total = 0;
   int bad   = 0;

   mem_access_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .r(r), .ex_wb(ex_wb), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .alu_result(alu_result), .store_data(store_data), .ex_rd(ex_rd),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata), .wb_ctrl(wb_ctrl),
      .wb_data(wb_data), .wb_rd(wb_rd), .stall(stall), .exc(exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an outstanding request, its wait time, and a pending result.
   // pend: 0 none, 1 completed, 2 misaligned, 3 timed out.
   int          m_busy, m_pend, m_wait;
   logic        m_we;
   logic [31:0] m_addr, m_wdata, m_ld;

   always @(posedge clk or negedge r) begin
      if (!r) begin
         m_busy = 0; m_pend = 0; m_wait = 0;
         m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_ld = 32'd0;
      end else if (m_busy != 0) begin
         m_wait++;
         if (dm_ready) begin
            m_busy = 0;
            m_pend = 1;
            if (!m_we) m_ld = dm_rdata;
         end else if (m_wait == TMO) begin
            m_busy = 0;
            m_pend = 3;
         end
      end else if (m_pend != 0) begin
         m_pend = 0;
      end else if (mem_rd || mem_wr) begin
         if (alu_result[1:0] != 2'b00) begin
            m_pend = 2;
         end else begin
            m_busy  = 1;
            m_wait  = 0;
            m_we    = mem_wr;
            m_addr  = alu_result;
            m_wdata = store_data;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      logic        e_stall, e_req;
      logic [1:0]  e_ctrl, e_exc;
      logic [31:0] e_data;
      if (r) begin
         e_req = (m_busy != 0);
         e_exc = 2'b00;
         e_data = alu_result;
         if (m_busy != 0) begin
            e_stall = 1'b1; e_ctrl = 2'b00;
         end else if (m_pend != 0) begin
            e_stall = 1'b0;
            if (m_pend == 1) begin
               e_ctrl = ex_wb;
               e_data = m_we ? alu_result : m_ld;
            end else begin
               e_ctrl = 2'b00;
               e_data = 32'd0;
               e_exc  = (m_pend == 3) ? 2'b10 : 2'b01;
            end
         end else if (mem_rd || mem_wr) begin
            e_stall = 1'b1; e_ctrl = 2'b00;
         end else begin
            e_stall = 1'b0; e_ctrl = ex_wb;
         end
         chk("m_stall", 32'(stall), 32'(e_stall));
         chk("m_wb_ctrl", 32'(wb_ctrl), 32'(e_ctrl));
         chk("m_wb_rd", 32'(wb_rd), 32'(ex_rd));
         chk("m_exc", 32'(exc), 32'(e_exc));
         chk("m_dm_req", 32'(dm_req), 32'(e_req));
         if (!e_stall) chk("m_wb_data", wb_data, e_data);
         if (e_req) begin
            chk("m_dm_we", 32'(dm_we), 32'(m_we));
            chk("m_dm_addr", dm_addr, m_addr);
            chk("m_dm_wdata", dm_wdata, m_wdata);
         end
      end
   end

   // Present one memory instruction, act as the memory, and report what the stage did.
   // ready_at: which request cycle (1-based) gets dm_ready; 0 means never.
   task automatic run_mem(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] wb,
                          input int ready_at, input logic [31:0] rdata,
                          output int stalls, output int reqs,
                          output logic [1:0] h_ctrl, output logic [1:0] h_exc,
                          output logic [31:0] h_data);
      bit done = 0;
      mem_rd = rd; mem_wr = wr; alu_result = addr; store_data = wdata;
      ex_wb = wb; ex_rd = 5'd7; dm_rdata = rdata;
      stalls = 0; reqs = 0; h_ctrl = 2'b11; h_exc = 2'b11; h_data = 32'hFFFF_FFFF;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (dm_req) begin
            reqs++;
            chk("req_we", 32'(dm_we), 32'(wr));
            chk("req_addr", dm_addr, addr);
            chk("req_wdata", dm_wdata, wdata);
            if (reqs == ready_at) dm_ready = 1'b1;
         end
         if (stall) begin
            stalls++;
         end else begin
            h_ctrl = wb_ctrl; h_exc = exc; h_data = wb_data;
            done = 1;
         end
         @(posedge clk); #1;
         dm_ready = 1'b0;
      end
      if (!done) chk("run_bound", 32'd0, 32'd1);
      mem_rd = 1'b0; mem_wr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st, rq;
      logic [1:0]  hc, he;
      logic [31:0] hd;
      r = 1'b0; ex_wb = 2'b00; mem_rd = 1'b0; mem_wr = 1'b0;
      alu_result = 32'd0; store_data = 32'd0; ex_rd = 5'd0;
      dm_ready = 1'b0; dm_rdata = 32'd0;
      @(negedge clk); @(negedge clk);
      chk("rst_dm_req", 32'(dm_req), 32'd0);
      chk("rst_dm_we", 32'(dm_we), 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_wdata", dm_wdata, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_exc", 32'(exc), 32'd0);
      @(posedge clk); #1;
      r = 1'b1;

      // ALU pass-through, zero latency
      ex_wb = 2'b10; alu_result = 32'h5; ex_rd = 5'd3;
      @(negedge clk);
      chk("alu_wb_ctrl", 32'(wb_ctrl), 32'd2);
      chk("alu_wb_data", wb_data, 32'h5);
      chk("alu_wb_rd", 32'(wb_rd), 32'd3);
      chk("alu_stall", 32'(stall), 32'd0);

      // dm_ready outside ACCESS is ignored
      @(posedge clk); #1;
      dm_ready = 1'b1; alu_result = 32'h44;
      @(negedge clk);
      chk("ign_stall", 32'(stall), 32'd0);
      chk("ign_req", 32'(dm_req), 32'd0);
      chk("ign_data", wb_data, 32'h44);
      @(posedge clk); #1;
      dm_ready = 1'b0;

      // Load 0x100, ready on third request cycle
      run_mem(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 3, 32'hDEADBEEF, st, rq, hc, he, hd);
      chk("ld_stalls", 32'(st), 32'd4);
      chk("ld_reqs", 32'(rq), 32'd3);
      chk("ld_ctrl", 32'(hc), 32'd3);
      chk("ld_data", hd, 32'hDEADBEEF);
      chk("ld_exc", 32'(he), 32'd0);

      // Back-to-back load, ready on first request cycle
      run_mem(1'b1, 1'b0, 32'h104, 32'h0, 2'b11, 1, 32'hCAFEF00D, st, rq, hc, he, hd);
      chk("ld1_stalls", 32'(st), 32'd2);
      chk("ld1_data", hd, 32'hCAFEF00D);

      // Store 0x200
      run_mem(1'b0, 1'b1, 32'h200, 32'h1234, 2'b00, 2, 32'h0, st, rq, hc, he, hd);
      chk("st_stalls", 32'(st), 32'd3);
      chk("st_reqs", 32'(rq), 32'd2);
      chk("st_ctrl", 32'(hc), 32'd0);
      chk("st_exc", 32'(he), 32'd0);

      // Read and write together behave as a store
      run_mem(1'b1, 1'b1, 32'h208, 32'h55AA, 2'b10, 1, 32'h9999, st, rq, hc, he, hd);
      chk("rw_ctrl", 32'(hc), 32'd2);
      chk("rw_data", hd, 32'h208);

      // Misaligned load
      run_mem(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 1, 32'h0, st, rq, hc, he, hd);
      chk("mis_reqs", 32'(rq), 32'd0);
      chk("mis_stalls", 32'(st), 32'd1);
      chk("mis_exc", 32'(he), 32'd1);
      chk("mis_ctrl", 32'(hc), 32'd0);
      chk("mis_data", hd, 32'd0);

      // Bus timeout
      run_mem(1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 0, 32'h0, st, rq, hc, he, hd);
      chk("tmo_reqs", 32'(rq), 32'd16);
      chk("tmo_stalls", 32'(st), 32'd17);
      chk("tmo_exc", 32'(he), 32'd2);
      chk("tmo_ctrl", 32'(hc), 32'd0);
      @(negedge clk);
      chk("tmo_exc_gone", 32'(exc), 32'd0);
      @(posedge clk); #1;

      // Reset while a request is outstanding
      mem_rd = 1'b1; alu_result = 32'h400; ex_wb = 2'b11;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_req", 32'(dm_req), 32'd1);
      #2 r = 1'b0;
      #1;
      chk("rst_mid_req", 32'(dm_req), 32'd0);
      chk("rst_mid_exc", 32'(exc), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      r = 1'b1;
      run_mem(1'b1, 1'b0, 32'h400, 32'h0, 2'b11, 1, 32'h0BADF00D, st, rq, hc, he, hd);
      chk("post_rst_stalls", 32'(st), 32'd2);
      chk("post_rst_data", hd, 32'h0BADF00D);

      ex_wb = 2'b00;
      @(negedge clk);
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
